// File: rtl/nco_ctrl_pkg.sv
// Shared types and widths for the NCO sweep controller.
// Provides the state encoding, the shadow configuration record and the saturating step helper.
package nco_ctrl_pkg;
  localparam int FREQ_W = 32;
  localparam int AUL_W  = 8;
  localparam int PHI_W  = 22;

  typedef enum logic {IDLE, RUN} sweep_state_t;

  typedef struct packed {
    logic [FREQ_W-1:0] f_start;
    logic [FREQ_W-1:0] f_stop;
    logic [FREQ_W-1:0] f_step;
    logic [AUL_W-1:0]  aul;
    logic              rpt;
  } sweep_cfg_t;

  // One extra bit catches the carry, so an overflowing step clamps to stop.
  function automatic logic [FREQ_W-1:0] next_point(input logic [FREQ_W-1:0] cur,
                                                   input logic [FREQ_W-1:0] step,
                                                   input logic [FREQ_W-1:0] stop);
    logic [FREQ_W:0] sum;
    sum = {1'b0, cur} + {1'b0, step};
    return (sum > {1'b0, stop}) ? stop : sum[FREQ_W-1:0];
  endfunction
endpackage

// File: rtl/nco_dwell_timer.sv
// Loadable down-counter that times how long each sweep point is held.
// expired is high while the count sits at zero.
module nco_dwell_timer #(
  parameter int DWELL_W = 24
) (
  input  logic               CLOCK,
  input  logic               rst,
  input  logic               load,
  input  logic [DWELL_W-1:0] value,
  output logic               expired
);
  logic [DWELL_W-1:0] cnt;

  always_ff @(posedge CLOCK) begin
    if (rst)               cnt <= '0;
    else if (load)         cnt <= value;
    else if (cnt != '0)    cnt <= cnt - DWELL_W'(1);
  end

  assign expired = (cnt == '0);
endmodule

// File: rtl/nco_sweep_ctrl.sv
// Stepped-frequency sweep sequencer feeding the NCO para_freq/para_aul words.
// Shadow config is captured in IDLE and only takes effect on the next start.
module nco_sweep_ctrl
  import nco_ctrl_pkg::*;
#(
  parameter int DWELL_W = 24
) (
  input  logic               CLOCK,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [FREQ_W-1:0]  cfg_f_start,
  input  logic [FREQ_W-1:0]  cfg_f_stop,
  input  logic [FREQ_W-1:0]  cfg_f_step,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic [AUL_W-1:0]   cfg_aul,
  input  logic               cfg_repeat,
  input  logic               start,
  input  logic               abort,
  output logic [FREQ_W-1:0]  para_freq,
  output logic [AUL_W-1:0]   para_aul,
  output logic               busy,
  output logic               step_stb,
  output logic               wrap_stb,
  output logic               sweep_done
);
  sweep_state_t       state;
  sweep_cfg_t         shd;
  logic [DWELL_W-1:0] shd_dwell;
  logic               cfg_loaded;
  logic               cfg_hs, go_start, at_stop, point_end, tmr_load, tmr_expired;

  always_comb begin
    cfg_hs    = cfg_valid & cfg_ready;
    go_start  = (state == IDLE) & start & cfg_loaded & ~abort;
    at_stop   = (para_freq >= shd.f_stop);
    point_end = (state == RUN) & ~abort & tmr_expired;
    tmr_load  = go_start | (point_end & (~at_stop | shd.rpt));
  end

  nco_dwell_timer #(.DWELL_W(DWELL_W)) u_dwell (
    .CLOCK   (CLOCK),
    .rst     (rst),
    .load    (tmr_load),
    .value   (shd_dwell),
    .expired (tmr_expired)
  );

  always_ff @(posedge CLOCK) begin
    if (rst) begin
      state      <= IDLE;
      shd        <= '0;
      shd_dwell  <= '0;
      cfg_loaded <= 1'b0;
      cfg_ready  <= 1'b1;
      para_freq  <= '0;
      para_aul   <= '0;
      busy       <= 1'b0;
      step_stb   <= 1'b0;
      wrap_stb   <= 1'b0;
      sweep_done <= 1'b0;
    end else begin
      step_stb   <= 1'b0;
      wrap_stb   <= 1'b0;
      sweep_done <= 1'b0;

      // start in the same cycle still sees the previous shadow values
      if (cfg_hs) begin
        shd.f_start <= cfg_f_start;
        shd.f_stop  <= cfg_f_stop;
        shd.f_step  <= (cfg_f_step == '0) ? FREQ_W'(1) : cfg_f_step;
        shd.aul     <= cfg_aul;
        shd.rpt     <= cfg_repeat;
        shd_dwell   <= cfg_dwell;
        cfg_loaded  <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (go_start) begin
            state     <= RUN;
            busy      <= 1'b1;
            cfg_ready <= 1'b0;
            para_freq <= shd.f_start;
            para_aul  <= shd.aul;
            step_stb  <= 1'b1;
          end
        end
        RUN: begin
          if (abort) begin
            state     <= IDLE;
            busy      <= 1'b0;
            cfg_ready <= 1'b1;
            para_aul  <= '0;
          end else if (point_end) begin
            if (!at_stop) begin
              para_freq <= next_point(para_freq, shd.f_step, shd.f_stop);
              step_stb  <= 1'b1;
            end else if (shd.rpt) begin
              para_freq <= shd.f_start;
              step_stb  <= 1'b1;
              wrap_stb  <= 1'b1;
            end else begin
              state      <= IDLE;
              busy       <= 1'b0;
              cfg_ready  <= 1'b1;
              para_aul   <= '0;
              sweep_done <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Directed bench for nco_sweep_ctrl: hand-computed sweep sequences checked cycle by cycle.
// Inputs change and outputs are sampled on the falling edge.
module tb_nco_sweep_ctrl;
  logic        CLOCK = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [31:0] cfg_f_start = '0, cfg_f_stop = '0, cfg_f_step = '0;
  logic [23:0] cfg_dwell = '0;
  logic [7:0]  cfg_aul = '0;
  logic        cfg_repeat = 1'b0;
  logic        start = 1'b0, abort = 1'b0;
  logic [31:0] para_freq;
  logic [7:0]  para_aul;
  logic        busy, step_stb, wrap_stb, sweep_done;

  int checks = 0;
  int errors = 0;
  int stb_cnt;
  logic [31:0] nonint_pts [4] = '{32'd1000, 32'd1100, 32'd1200, 32'd1250};
  logic [31:0] sat_pts    [4] = '{32'hFFFFFF00, 32'hFFFFFF00, 32'hFFFFFFFF, 32'hFFFFFFFF};

  nco_sweep_ctrl #(.DWELL_W(24)) dut (
    .CLOCK(CLOCK), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_f_start(cfg_f_start), .cfg_f_stop(cfg_f_stop), .cfg_f_step(cfg_f_step),
    .cfg_dwell(cfg_dwell), .cfg_aul(cfg_aul), .cfg_repeat(cfg_repeat),
    .start(start), .abort(abort), .para_freq(para_freq), .para_aul(para_aul),
    .busy(busy), .step_stb(step_stb), .wrap_stb(wrap_stb), .sweep_done(sweep_done)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic cyc();
    @(negedge CLOCK);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_cfg(input logic [31:0] fs, input logic [31:0] fe, input logic [31:0] st,
                         input logic [23:0] dw, input logic [7:0] au, input logic rp);
    cfg_f_start = fs; cfg_f_stop = fe; cfg_f_step = st;
    cfg_dwell = dw; cfg_aul = au; cfg_repeat = rp;
  endtask

  task automatic load_cfg(input logic [31:0] fs, input logic [31:0] fe, input logic [31:0] st,
                          input logic [23:0] dw, input logic [7:0] au, input logic rp);
    set_cfg(fs, fe, st, dw, au, rp);
    cfg_valid = 1'b1;
    cyc();
    cfg_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  initial begin
    cyc(); cyc();
    rst = 1'b0;
    cyc();
    chk("rst_freq", para_freq, 32'd0);
    chk("rst_aul", {24'd0, para_aul}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ready", {31'd0, cfg_ready}, 32'd1);
    chk("rst_strobes", {29'd0, step_stb, wrap_stb, sweep_done}, 32'd0);

    // start with nothing loaded
    pulse_start();
    chk("nocfg_busy", {31'd0, busy}, 32'd0);
    chk("nocfg_stb", {31'd0, step_stb}, 32'd0);

    // basic sweep
    load_cfg(32'd1000, 32'd1300, 32'd100, 24'd3, 8'd200, 1'b0);
    chk("cfg_no_effect", para_freq, 32'd0);
    chk("cfg_ready_idle", {31'd0, cfg_ready}, 32'd1);
    pulse_start();
    stb_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      chk("basic_freq", para_freq, 32'd1000 + 32'd100 * 32'(i / 4));
      chk("basic_busy", {31'd0, busy}, 32'd1);
      chk("basic_aul", {24'd0, para_aul}, 32'd200);
      chk("basic_stb", {31'd0, step_stb}, (i % 4 == 0) ? 32'd1 : 32'd0);
      chk("basic_done_early", {31'd0, sweep_done}, 32'd0);
      stb_cnt += int'(step_stb);
      cyc();
    end
    chk("basic_stb_count", 32'(stb_cnt), 32'd4);
    chk("basic_end_busy", {31'd0, busy}, 32'd0);
    chk("basic_done", {31'd0, sweep_done}, 32'd1);
    chk("basic_end_aul", {24'd0, para_aul}, 32'd0);
    chk("basic_end_freq", para_freq, 32'd1300);
    cyc();
    chk("basic_done_pulse", {31'd0, sweep_done}, 32'd0);

    // non-integer span
    load_cfg(32'd1000, 32'd1250, 32'd100, 24'd0, 8'd50, 1'b0);
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      chk("nonint_freq", para_freq, nonint_pts[i]);
      cyc();
    end
    chk("nonint_done", {31'd0, sweep_done}, 32'd1);

    // saturating add
    load_cfg(32'hFFFFFF00, 32'hFFFFFFFF, 32'h200, 24'd1, 8'd9, 1'b0);
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      chk("sat_freq", para_freq, sat_pts[i]);
      chk("sat_busy", {31'd0, busy}, 32'd1);
      cyc();
    end
    chk("sat_done", {31'd0, sweep_done}, 32'd1);

    // repeat mode, then abort
    load_cfg(32'd10, 32'd30, 32'd10, 24'd0, 8'd77, 1'b1);
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      chk("rpt_freq", para_freq, 32'd10 * 32'(i % 3 + 1));
      chk("rpt_wrap", {31'd0, wrap_stb}, (i == 3 || i == 6) ? 32'd1 : 32'd0);
      chk("rpt_stb", {31'd0, step_stb}, 32'd1);
      chk("rpt_no_done", {31'd0, sweep_done}, 32'd0);
      cyc();
    end
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk("rpt_abort_busy", {31'd0, busy}, 32'd0);
    chk("rpt_abort_freq", para_freq, 32'd30);
    chk("rpt_abort_aul", {24'd0, para_aul}, 32'd0);
    chk("rpt_abort_done", {31'd0, sweep_done}, 32'd0);

    // abort during second point, then rerun
    load_cfg(32'd1000, 32'd1300, 32'd100, 24'd3, 8'd200, 1'b0);
    pulse_start();
    repeat (5) cyc();
    chk("abort_pt2", para_freq, 32'd1100);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_aul", {24'd0, para_aul}, 32'd0);
    chk("abort_freq", para_freq, 32'd1100);
    chk("abort_done", {31'd0, sweep_done}, 32'd0);
    cyc();
    chk("abort_done_later", {31'd0, sweep_done}, 32'd0);
    pulse_start();
    chk("rerun_freq", para_freq, 32'd1000);
    chk("rerun_stb", {31'd0, step_stb}, 32'd1);

    // config while busy must not be captured
    set_cfg(32'd5555, 32'd6000, 32'd1, 24'd0, 8'd1, 1'b0);
    cfg_valid = 1'b1;
    chk("busy_ready", {31'd0, cfg_ready}, 32'd0);
    cyc();
    cfg_valid = 1'b0;
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    pulse_start();
    chk("no_capture_freq", para_freq, 32'd1000);
    chk("no_capture_aul", {24'd0, para_aul}, 32'd200);

    // reset mid-sweep
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("mrst_freq", para_freq, 32'd0);
    chk("mrst_aul", {24'd0, para_aul}, 32'd0);
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_ready", {31'd0, cfg_ready}, 32'd1);
    chk("mrst_stb", {29'd0, step_stb, wrap_stb, sweep_done}, 32'd0);
    pulse_start();
    chk("mrst_unloaded", {31'd0, busy}, 32'd0);

    // cfg_valid with start and nothing previously loaded
    set_cfg(32'd20, 32'd40, 32'd10, 24'd0, 8'd7, 1'b0);
    cfg_valid = 1'b1;
    start = 1'b1;
    cyc();
    cfg_valid = 1'b0;
    start = 1'b0;
    chk("simul_ignored", {31'd0, busy}, 32'd0);
    pulse_start();
    chk("simul_freq", para_freq, 32'd20);
    chk("simul_aul", {24'd0, para_aul}, 32'd7);
    repeat (3) cyc();
    chk("simul_done", {31'd0, sweep_done}, 32'd1);

    // abort together with start in IDLE
    abort = 1'b1;
    start = 1'b1;
    cyc();
    abort = 1'b0;
    start = 1'b0;
    chk("abort_start_idle", {31'd0, busy}, 32'd0);

    // zero step stored as one
    load_cfg(32'd5, 32'd6, 32'd0, 24'd0, 8'd3, 1'b0);
    pulse_start();
    cyc();
    chk("zero_step", para_freq, 32'd6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
